baud_gen_frac: RTL and testbench

Parametrised fractional baud-rate generator that turns one system clock into a UART receive enable (oversampled) and a transmit enable. A phase accumulator with a programmable increment reaches standard baud rates to within ppm on any clock. The transmit tick is derived from the receive ticks, so the two stay phase-locked. It sits between the system clock and the UART rx/tx engines. Over the base divider it adds a runtime rate change via handshake, an enable input and receive phase resync.

---
 rtl/baud_gen_frac.sv | 119 +++++++++++
 tb/tb_baud_gen_frac.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// baud_gen_frac
// Fractional baud-rate generator. A phase accumulator adds a programmable
// increment every enabled cycle; each carry out is one rx oversample tick.
// Every OVERSAMPLE-th rx tick is also a tx bit tick, so rx and tx stay
// phase-locked.
//
// Ports
//   clk_50m    in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   run enable; low freezes acc/ovs and silences both enables
//   rx_sync    in   one-cycle pulse, realigns rx phase to a start-bit edge
//   cfg_inc    in   new phase increment
//   cfg_valid  in   cfg_inc valid
//   cfg_ready  out  a new increment can be accepted (no update pending)
//   rxclk_en   out  one-cycle rx oversample enable
//   txclk_en   out  one-cycle tx bit enable (only ever with rxclk_en)
module baud_gen_frac #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned ACC_WIDTH  = 24,
  // round(BAUD * OVERSAMPLE * 2^ACC_WIDTH / CLK_HZ), done in 64-bit integer math
  parameter logic [ACC_WIDTH-1:0] INC_DEFAULT =
    ACC_WIDTH'(((((64'(BAUD) * 64'(OVERSAMPLE)) << ACC_WIDTH) * 64'd2) + 64'(CLK_HZ))
               / (64'(CLK_HZ) * 64'd2))
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 rx_sync,
  input  logic [ACC_WIDTH-1:0] cfg_inc,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic                 rxclk_en,
  output logic                 txclk_en
);

  localparam int unsigned OVS_W = $clog2(OVERSAMPLE);
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVERSAMPLE - 1);
  localparam logic [OVS_W-1:0] OVS_MID  = OVS_W'(OVERSAMPLE / 2);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] inc_q, inc_d;
  logic [ACC_WIDTH-1:0] pend_inc_q, pend_inc_d;
  logic                 pend_q, pend_d;
  logic [OVS_W-1:0]     ovs_q, ovs_d;
  logic                 rx_en_q, rx_en_d;
  logic                 tx_en_q, tx_en_d;

  logic [ACC_WIDTH:0]   sum;
  logic                 carry;
  logic                 ovs_last;
  logic                 tx_hit;
  logic                 apply;

  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, inc_q};
    carry    = sum[ACC_WIDTH];
    ovs_last = (ovs_q == OVS_LAST);
    tx_hit   = carry & ovs_last;
    // A pending rate lands on a bit boundary so the next bit runs entirely
    // at the new rate; while frozen there is no boundary to wait for.
    apply    = pend_q & (~en | tx_hit);

    acc_d      = acc_q;
    inc_d      = inc_q;
    pend_inc_d = pend_inc_q;
    pend_d     = pend_q;
    ovs_d      = ovs_q;
    rx_en_d    = 1'b0;
    tx_en_d    = 1'b0;

    if (rx_sync) begin
      // Starting half a bit into the ovs count puts the first tx tick mid-bit.
      acc_d = '0;
      ovs_d = OVS_MID;
    end else if (en) begin
      acc_d   = sum[ACC_WIDTH-1:0];
      rx_en_d = carry;
      tx_en_d = tx_hit;
      if (carry) begin
        ovs_d = ovs_last ? '0 : ovs_q + 1'b1;
      end
    end

    if (apply) begin
      inc_d  = pend_inc_q;
      pend_d = 1'b0;
    end else if (cfg_valid && !pend_q) begin
      pend_inc_d = cfg_inc;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      acc_q      <= '0;
      inc_q      <= INC_DEFAULT;
      pend_inc_q <= '0;
      pend_q     <= 1'b0;
      ovs_q      <= '0;
      rx_en_q    <= 1'b0;
      tx_en_q    <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      inc_q      <= inc_d;
      pend_inc_q <= pend_inc_d;
      pend_q     <= pend_d;
      ovs_q      <= ovs_d;
      rx_en_q    <= rx_en_d;
      tx_en_q    <= tx_en_d;
    end
  end

  assign cfg_ready = ~pend_q;
  assign rxclk_en  = rx_en_q;
  assign txclk_en  = tx_en_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
module tb_baud_gen_frac;

  localparam int AW = 24;

  logic          clk_50m = 1'b0;
  logic          rst;
  logic          en;
  logic          rx_sync;
  logic [AW-1:0] cfg_inc;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          rxclk_en;
  logic          txclk_en;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_50m = ~clk_50m;

  baud_gen_frac dut (
    .clk_50m  (clk_50m),
    .rst      (rst),
    .en       (en),
    .rx_sync  (rx_sync),
    .cfg_inc  (cfg_inc),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .rxclk_en (rxclk_en),
    .txclk_en (txclk_en)
  );

  typedef struct {
    logic          rst;
    logic          en;
    logic          sync;
    logic          cv;
    logic [AW-1:0] ci;
    logic [2:0]    exp;   // {rxclk_en, txclk_en, cfg_ready}
    string         name;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic [2:0] exp);
    chk(name, {29'd0, rxclk_en, txclk_en, cfg_ready}, {29'd0, exp});
  endtask

  // Reset, then load inc with en=0 so it applies on the following edge.
  // Leaves acc=0, ovs=0, no update pending, en=0.
  task automatic reset_program(input logic [AW-1:0] inc);
    rst = 1'b1; en = 1'b0; rx_sync = 1'b0; cfg_valid = 1'b0; cfg_inc = '0;
    tick();
    tick();
    rst = 1'b0;
    cfg_valid = 1'b1; cfg_inc = inc;
    tick();
    cfg_valid = 1'b0;
    tick();
  endtask

  initial begin
    logic xr, xt, xd;
    int   rx_cnt, tx_cnt, tx_alone;

    rst = 1'b1; en = 1'b0; rx_sync = 1'b0; cfg_valid = 1'b0; cfg_inc = '0;

    //            rst   en    sync  cv    cfg_inc       {rx,tx,rdy}
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 24'h123456, 3'b001, "rst_overrides"};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 3'b001, "rst_hold"};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 24'h400000, 3'b000, "cfg_accept"};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 24'h000001, 3'b001, "apply_en0"};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 3'b001, "run_e1"};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 3'b001, "run_e2"};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 3'b001, "run_e3"};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 3'b101, "first_rx"};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 3'b001, "rx_one_wide"};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 3'b001, "frozen"};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 24'h000000, 3'b001, "sync_quiet"};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 3'b001, "post_sync1"};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 3'b001, "post_sync2"};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 3'b001, "post_sync3"};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 3'b101, "post_sync4"};

    for (int i = 0; i < 15; i++) begin
      rst = vecs[i].rst; en = vecs[i].en; rx_sync = vecs[i].sync;
      cfg_valid = vecs[i].cv; cfg_inc = vecs[i].ci;
      tick();
      chk_outs(vecs[i].name, vecs[i].exp);
    end

    // Exact divide by 4: rx every 4 edges, tx on every 16th rx tick.
    reset_program(24'h400000);
    en = 1'b1;
    for (int e = 1; e <= 130; e++) begin
      tick();
      chk_outs($sformatf("exact_e%0d", e), {e % 4 == 0, e % 64 == 0, 1'b1});
    end

    // Rate change mid-bit, with a second request inside the pending window.
    reset_program(24'h400000);
    en = 1'b1;
    for (int e = 1; e <= 128; e++) begin
      cfg_valid = (e == 21) || (e == 30);
      cfg_inc   = (e == 21) ? 24'h800000 : 24'h200000;
      tick();
      if (e <= 64) begin
        xr = (e % 4 == 0); xt = (e == 64); xd = !(e >= 21 && e < 64);
      end else begin
        xr = ((e - 64) % 2 == 0); xt = ((e - 64) % 32 == 0); xd = 1'b1;
      end
      chk_outs($sformatf("rate_e%0d", e), {xr, xt, xd});
    end
    cfg_valid = 1'b0;

    // Freeze for 10 cycles mid-bit.
    reset_program(24'h400000);
    for (int e = 1; e <= 80; e++) begin
      en = !(e >= 21 && e <= 30);
      tick();
      if (e <= 20) begin
        xr = (e % 4 == 0); xt = 1'b0;
      end else if (e <= 30) begin
        xr = 1'b0; xt = 1'b0;
      end else begin
        xr = ((e - 10) % 4 == 0); xt = ((e - 10) % 64 == 0);
      end
      chk_outs($sformatf("freeze_e%0d", e), {xr, xt, 1'b1});
    end

    // Resync on an edge that would otherwise have carried.
    reset_program(24'h400000);
    en = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      rx_sync = (e == 12);
      tick();
      if (e < 12) begin
        xr = (e % 4 == 0); xt = 1'b0;
      end else if (e == 12) begin
        xr = 1'b0; xt = 1'b0;
      end else begin
        xr = ((e - 12) % 4 == 0);
        xt = xr && (((e - 12) / 4) % 16 == 8);
      end
      chk_outs($sformatf("sync_e%0d", e), {xr, xt, 1'b1});
    end
    rx_sync = 1'b0;

    // inc=0: silent; an update queued behind it waits for en=0.
    reset_program(24'h000000);
    en = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      cfg_valid = (e == 5); cfg_inc = 24'h400000;
      tick();
      chk_outs($sformatf("zero_e%0d", e), {1'b0, 1'b0, e < 5});
    end
    cfg_valid = 1'b0;
    en = 1'b0;
    tick();
    chk_outs("zero_apply_en0", 3'b001);
    en = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk_outs($sformatf("zero_resume_e%0d", e), {e == 4, 1'b0, 1'b1});
    end

    // Mid-operation reset with an update pending, then default-rate run.
    reset_program(24'h400000);
    en = 1'b1;
    for (int e = 1; e <= 6; e++) tick();
    cfg_valid = 1'b1; cfg_inc = 24'h800000;
    tick();
    chk_outs("midrst_pend", 3'b000);
    cfg_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk_outs("midrst_outs", 3'b001);
    rst = 1'b0;
    rx_cnt = 0; tx_cnt = 0; tx_alone = 0;
    for (int c = 1; c <= 50000; c++) begin
      tick();
      if (rxclk_en) rx_cnt++;
      if (txclk_en) tx_cnt++;
      if (txclk_en && !rxclk_en) tx_alone++;
      if (c <= 28) chk_outs($sformatf("default_e%0d", c), {c == 28, 1'b0, 1'b1});
    end

    n_vec++;
    if (rx_cnt < 1842 || rx_cnt > 1844) begin
      n_err++;
      $display("FAIL default_rx_count: got %0d expected 1843 +-1", rx_cnt);
    end
    n_vec++;
    if (tx_cnt < 114 || tx_cnt > 116) begin
      n_err++;
      $display("FAIL default_tx_count: got %0d expected 115 +-1", tx_cnt);
    end
    chk("tx_without_rx", 32'(tx_alone), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
